// File: rtl/patch_scanner_pkg.sv
// Shared definitions for the patch scanner: default image geometry,
// legal patch sizes, counter width and the scanner FSM states.
package patch_scanner_pkg;

    localparam int IMG_DIM   = 28;  // square booleanized image, pixels per side
    localparam int MAX_PATCH = 7;   // widest patch; width of the pixels bus
    localparam int CNT_W     = 5;   // width of row/column counters and bounds

    localparam logic [2:0] PATCH_3 = 3'd3;
    localparam logic [2:0] PATCH_5 = 3'd5;
    localparam logic [2:0] PATCH_7 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic patch_size_ok(input logic [2:0] p);
        return (p == PATCH_3) || (p == PATCH_5) || (p == PATCH_7);
    endfunction

endpackage

// File: rtl/image_buffer.sv
// Image row store for the patch scanner.
// Ports:
//   clk      - clock
//   wr_en    - write wr_data into row wr_row (rows >= IMG_DIM are ignored)
//   wr_row   - row index to write
//   wr_data  - row bits, bit x = column x
//   rd_base  - first row of the asynchronous read window
//   rd_rows  - rows rd_base .. rd_base+MAX_PATCH-1; rows past the image read 0
module image_buffer
    import patch_scanner_pkg::*;
#(
    parameter int IMG_DIM   = patch_scanner_pkg::IMG_DIM,
    parameter int MAX_PATCH = patch_scanner_pkg::MAX_PATCH
) (
    input  logic                               clk,
    input  logic                               wr_en,
    input  logic [CNT_W-1:0]                   wr_row,
    input  logic [IMG_DIM-1:0]                 wr_data,
    input  logic [CNT_W-1:0]                   rd_base,
    output logic [MAX_PATCH-1:0][IMG_DIM-1:0]  rd_rows
);

    localparam logic [CNT_W:0] DIM_C = (CNT_W+1)'(IMG_DIM);

    // Image contents survive reset on purpose, so no reset branch here.
    logic [IMG_DIM-1:0] mem [IMG_DIM];

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_row} < DIM_C)) begin
            mem[wr_row] <= wr_data;
        end
    end

    // One extra bit on the index so base+i past the last row is detected
    // instead of wrapping back to the top of the image.
    logic [CNT_W:0] idx;

    always_comb begin
        idx     = '0;
        rd_rows = '0;
        for (int i = 0; i < MAX_PATCH; i++) begin
            idx = {1'b0, rd_base} + (CNT_W+1)'(i);
            if (idx < DIM_C) begin
                rd_rows[i] = mem[idx[CNT_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/patch_scanner.sv
// Patch scanner: streams an image column by column, one band of P rows at a
// time, to a convolution stage, flagging window origins inside a match box.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   wr_en, wr_row, wr_data    - image row write (accepted in IDLE only)
//   patch_size                - 3, 5 or 7; latched on an accepted start
//   x_min/x_max/y_min/y_max   - inclusive window-origin match box; latched on start
//   start                     - one-cycle scan request
//   busy, done, err_patch     - scan status; err_patch flags a bad patch_size
//   pixels                    - column slice, bit i = row y0+i, bits >= P are 0
//   pe_enable, conv_enable    - high on every streamed column
//   Xmatch, Ymatch            - window origin inside the x / y match range
module patch_scanner
    import patch_scanner_pkg::*;
#(
    parameter int IMG_DIM   = patch_scanner_pkg::IMG_DIM,
    parameter int MAX_PATCH = patch_scanner_pkg::MAX_PATCH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [CNT_W-1:0]      wr_row,
    input  logic [IMG_DIM-1:0]    wr_data,
    input  logic [2:0]            patch_size,
    input  logic [CNT_W-1:0]      x_min,
    input  logic [CNT_W-1:0]      x_max,
    input  logic [CNT_W-1:0]      y_min,
    input  logic [CNT_W-1:0]      y_max,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err_patch,
    output logic [MAX_PATCH-1:0]  pixels,
    output logic                  pe_enable,
    output logic                  conv_enable,
    output logic                  Xmatch,
    output logic                  Ymatch
);

    localparam int             DRAIN_W    = $clog2(MAX_PATCH + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAX_PATCH - 1);
    localparam logic [CNT_W-1:0]   DIM_C      = CNT_W'(IMG_DIM);
    localparam logic [CNT_W-1:0]   X_LAST     = CNT_W'(IMG_DIM - 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     x_cnt, y_cnt, x_nxt, y_nxt;
    logic [DRAIN_W-1:0]   drain_cnt, drain_nxt;
    logic                 emit;

    logic [2:0]           p_lat;
    logic [CNT_W-1:0]     xmin_lat, xmax_lat, ymin_lat, ymax_lat;

    logic                 accept, reject, wr_ok;
    logic [2:0]           p_use;
    logic [CNT_W-1:0]     xmin_use, xmax_use, ymin_use, ymax_use;
    logic [CNT_W-1:0]     last_origin;

    logic [MAX_PATCH-1:0][IMG_DIM-1:0] rd_rows;
    logic [IMG_DIM-1:0]   row_sel;
    logic [MAX_PATCH-1:0] pix_nxt;
    logic                 xm_nxt, ym_nxt;

    assign accept = (state == ST_IDLE) && start && patch_size_ok(patch_size);
    assign reject = (state == ST_IDLE) && start && !patch_size_ok(patch_size);
    assign wr_ok  = wr_en && (state == ST_IDLE) && (wr_row < DIM_C);

    // The first column is produced on the same edge that accepts start, so
    // the configuration is taken straight from the inputs on that edge.
    assign p_use    = accept ? patch_size : p_lat;
    assign xmin_use = accept ? x_min : xmin_lat;
    assign xmax_use = accept ? x_max : xmax_lat;
    assign ymin_use = accept ? y_min : ymin_lat;
    assign ymax_use = accept ? y_max : ymax_lat;

    // IMG_DIM-P: both the last band origin and the last column that can
    // start a window without straddling into the next band.
    assign last_origin = DIM_C - {{(CNT_W-3){1'b0}}, p_use};

    image_buffer #(
        .IMG_DIM   (IMG_DIM),
        .MAX_PATCH (MAX_PATCH)
    ) u_image_buffer (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .rd_base (y_nxt),
        .rd_rows (rd_rows)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // x_nxt/y_nxt name the column that goes out on the coming edge; emit says
    // whether that edge produces a streamed column at all.
    always_comb begin
        state_nxt = state;
        x_nxt     = x_cnt;
        y_nxt     = y_cnt;
        drain_nxt = drain_cnt;
        emit      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SCAN;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    emit      = 1'b1;
                end
            end
            ST_SCAN: begin
                emit = 1'b1;
                if (x_cnt == X_LAST) begin
                    x_nxt = '0;
                    if (y_cnt == last_origin) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = '0;
                        emit      = 1'b0;
                    end else begin
                        y_nxt = y_cnt + 1'b1;
                    end
                end else begin
                    x_nxt = x_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    drain_nxt = drain_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A row written in the same cycle as start is forwarded here, so the
    // first band already sees the new data.
    always_comb begin
        pix_nxt = '0;
        row_sel = '0;
        for (int i = 0; i < MAX_PATCH; i++) begin
            row_sel = rd_rows[i];
            if (wr_ok && ({1'b0, wr_row} == ({1'b0, y_nxt} + (CNT_W+1)'(i)))) begin
                row_sel = wr_data;
            end
            if (emit && (3'(i) < p_use)) begin
                pix_nxt[i] = row_sel[x_nxt];
            end
        end
    end

    assign xm_nxt = emit && (x_nxt <= last_origin) &&
                    (x_nxt >= xmin_use) && (x_nxt <= xmax_use);
    assign ym_nxt = emit && (y_nxt >= ymin_use) && (y_nxt <= ymax_use);

    // Output stage: every port is driven straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            drain_cnt   <= '0;
            p_lat       <= '0;
            xmin_lat    <= '0;
            xmax_lat    <= '0;
            ymin_lat    <= '0;
            ymax_lat    <= '0;
            pixels      <= '0;
            pe_enable   <= 1'b0;
            conv_enable <= 1'b0;
            Xmatch      <= 1'b0;
            Ymatch      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_patch   <= 1'b0;
        end else begin
            x_cnt     <= x_nxt;
            y_cnt     <= y_nxt;
            drain_cnt <= drain_nxt;
            if (accept) begin
                p_lat    <= patch_size;
                xmin_lat <= x_min;
                xmax_lat <= x_max;
                ymin_lat <= y_min;
                ymax_lat <= y_max;
            end
            pixels      <= pix_nxt;
            pe_enable   <= emit;
            conv_enable <= emit;
            Xmatch      <= xm_nxt;
            Ymatch      <= ym_nxt;
            busy        <= (state_nxt == ST_SCAN) || (state_nxt == ST_DRAIN);
            done        <= (state_nxt == ST_DONE);
            err_patch   <= reject;
        end
    end

endmodule

// File: tb/tb_patch_scanner.sv
// Directed bench for patch_scanner: checkerboard and custom images, all three
// patch sizes, match boxes, rejected start, busy-time writes, mid-scan reset.
module tb_patch_scanner;

    localparam int IMG  = 28;
    localparam int MAXP = 7;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_en = 1'b0;
    logic [4:0]      wr_row = '0;
    logic [IMG-1:0]  wr_data = '0;
    logic [2:0]      patch_size = '0;
    logic [4:0]      x_min = '0, x_max = '0, y_min = '0, y_max = '0;
    logic            start = 1'b0;
    logic            busy, done, err_patch;
    logic [MAXP-1:0] pixels;
    logic            pe_enable, conv_enable, Xmatch, Ymatch;

    patch_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .patch_size  (patch_size),
        .x_min       (x_min),
        .x_max       (x_max),
        .y_min       (y_min),
        .y_max       (y_max),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err_patch   (err_patch),
        .pixels      (pixels),
        .pe_enable   (pe_enable),
        .conv_enable (conv_enable),
        .Xmatch      (Xmatch),
        .Ymatch      (Ymatch)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [IMG-1:0] img [IMG];

    // per-scan observations
    int n_pe, pe_err, pix_err, hi_err, drain_err, busy_err, xm_err, ym_err;
    int xm_cnt, ym_cnt, joint_cnt, joint_pos, done_k, dn_cnt, err_cnt;
    int band_xm [IMG];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic write_row(input int r, input logic [IMG-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_row  = 5'(r);
        wr_data = d;
        img[r]  = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Runs one scan and gathers observations; wr_at writes inverted row 3
    // at that scan cycle (must be ignored), rst_at resets at that cycle,
    // sim_wr writes sim_row into row 0 together with start.
    task automatic run_scan(input int p, input int xmn, input int xmx,
                            input int ymn, input int ymx,
                            input int wr_at, input int rst_at,
                            input int sim_wr, input logic [IMG-1:0] sim_row);
        int n_scan, exp_done, y0, x;
        logic [MAXP-1:0] ep;
        logic exm, eym;
        n_pe = 0; pe_err = 0; pix_err = 0; hi_err = 0; drain_err = 0;
        busy_err = 0; xm_err = 0; ym_err = 0; xm_cnt = 0; ym_cnt = 0;
        joint_cnt = 0; joint_pos = -1; done_k = -1; dn_cnt = 0; err_cnt = 0;
        for (int b = 0; b < IMG; b++) band_xm[b] = 0;
        n_scan   = (IMG - p + 1) * IMG;
        exp_done = 1 + n_scan + MAXP;

        @(negedge clk);
        start      = 1'b1;
        patch_size = 3'(p);
        x_min = 5'(xmn); x_max = 5'(xmx); y_min = 5'(ymn); y_max = 5'(ymx);
        if (sim_wr != 0) begin
            wr_en = 1'b1; wr_row = 5'd0; wr_data = sim_row; img[0] = sim_row;
        end

        for (int k = 1; k <= exp_done + 4; k++) begin
            @(negedge clk);
            // config is scrambled after start; the scanner must hold its copy
            start = 1'b0; wr_en = 1'b0;
            patch_size = 3'd6; x_min = 5'd31; x_max = 5'd0; y_min = 5'd31; y_max = 5'd0;

            if (k == rst_at) begin
                chk("rst_pre_pe", {31'd0, pe_enable}, 32'd1);
                rst = 1'b1;
                #1;
                chk("rst_async_outs",
                    {18'd0, pixels, pe_enable, conv_enable, Xmatch, Ymatch, busy, done, err_patch}, 32'd0);
                @(negedge clk);
                chk("rst_hold_done", {31'd0, done}, 32'd0);
                rst = 1'b0;
                @(negedge clk);
                chk("rst_after_idle", {29'd0, busy, pe_enable, done}, 32'd0);
                return;
            end

            if (done) begin
                dn_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (err_patch) err_cnt++;
            if (busy !== (k < exp_done)) busy_err++;
            if (pe_enable !== (k <= n_scan)) pe_err++;

            if (pe_enable === 1'b1) begin
                y0 = n_pe / IMG;
                x  = n_pe % IMG;
                ep = '0;
                for (int i = 0; i < p; i++) ep[i] = img[y0 + i][x];
                if (pixels !== ep) pix_err++;
                if ((pixels >> p) != 0) hi_err++;
                exm = (x <= IMG - p) && (x >= xmn) && (x <= xmx);
                eym = (y0 >= ymn) && (y0 <= ymx);
                if (Xmatch !== exm) xm_err++;
                if (Ymatch !== eym) ym_err++;
                if (Xmatch === 1'b1) begin xm_cnt++; band_xm[y0]++; end
                if (Ymatch === 1'b1) ym_cnt++;
                if (Xmatch === 1'b1 && Ymatch === 1'b1) begin
                    joint_cnt++;
                    joint_pos = y0 * IMG + x;
                end
                if (conv_enable !== 1'b1) drain_err++;
                n_pe++;
            end else begin
                if (pixels !== '0 || Xmatch !== 1'b0 || Ymatch !== 1'b0 || conv_enable !== 1'b0)
                    drain_err++;
            end

            // a start while busy must be ignored, bad size or not
            if (k == 10) begin
                start = 1'b1; patch_size = 3'd4;
            end
            if (k == wr_at) begin
                wr_en = 1'b1; wr_row = 5'd3; wr_data = ~img[3];
            end
        end
    endtask

    int band_bad;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs",
            {18'd0, pixels, pe_enable, conv_enable, Xmatch, Ymatch, busy, done, err_patch}, 32'd0);

        // checkerboard: img[y][x] = (x+y) & 1
        for (int y = 0; y < IMG; y++)
            write_row(y, (y % 2 == 0) ? 28'hAAAAAAA : 28'h5555555);

        // P=3, box covers everything
        run_scan(3, 0, 31, 0, 31, 0, 0, 0, '0);
        chk("p3_pe_count", n_pe, 728);
        chk("p3_pe_shape", pe_err, 0);
        chk("p3_done_k", done_k, 736);
        chk("p3_done_once", dn_cnt, 1);
        chk("p3_pixels", pix_err, 0);
        chk("p3_hi_bits", hi_err, 0);
        chk("p3_drain", drain_err, 0);
        chk("p3_busy", busy_err, 0);
        chk("p3_xmatch", xm_err, 0);
        chk("p3_ymatch", ym_err, 0);
        chk("p3_ym_count", ym_cnt, 728);
        chk("busy_start_no_err", err_cnt, 0);

        // P=7, box 0..21 in both axes
        run_scan(7, 0, 21, 0, 21, 0, 0, 0, '0);
        chk("p7_pe_count", n_pe, 616);
        chk("p7_done_k", done_k, 624);
        chk("p7_ym_count", ym_cnt, 616);
        chk("p7_xm_total", xm_cnt, 22 * 22);
        band_bad = 0;
        for (int b = 0; b < 22; b++) if (band_xm[b] != 22) band_bad++;
        chk("p7_band_xm", band_bad, 0);
        chk("p7_pixels", pix_err, 0);
        chk("p7_xmatch", xm_err, 0);

        // P=5, single-point box at (x=4, y0=10)
        run_scan(5, 4, 4, 10, 10, 0, 0, 0, '0);
        chk("p5_pe_count", n_pe, 672);
        chk("p5_joint_count", joint_cnt, 1);
        chk("p5_joint_pos", joint_pos, 10 * 28 + 4);
        chk("p5_xm_count", xm_cnt, 24);
        chk("p5_ym_count", ym_cnt, 28);
        chk("p5_pixels", pix_err, 0);

        // rejected start
        @(negedge clk);
        start = 1'b1; patch_size = 3'd4;
        @(negedge clk);
        start = 1'b0;
        chk("rej_err_pulse", {31'd0, err_patch}, 32'd1);
        chk("rej_busy", {31'd0, busy}, 32'd0);
        chk("rej_pe", {31'd0, pe_enable}, 32'd0);
        @(negedge clk);
        chk("rej_err_clear", {31'd0, err_patch}, 32'd0);
        chk("rej_pe_later", {30'd0, pe_enable, busy}, 32'd0);

        // write to row 3 while busy must be dropped; next scan sees old row 3
        run_scan(3, 0, 31, 0, 31, 50, 0, 0, '0);
        chk("busywr_scan_pixels", pix_err, 0);
        run_scan(3, 0, 31, 0, 31, 0, 0, 0, '0);
        chk("busywr_after_pixels", pix_err, 0);
        chk("busywr_after_pe", n_pe, 728);

        // reset at scan cycle 100, then a full scan with a same-cycle row 0 write
        run_scan(3, 0, 31, 0, 31, 0, 100, 0, '0);
        chk("rst_no_done", dn_cnt, 0);
        run_scan(3, 2, 9, 5, 7, 0, 0, 1, 28'h5A3C0F1);
        chk("post_rst_pe", n_pe, 728);
        chk("post_rst_done_k", done_k, 736);
        chk("post_rst_pixels", pix_err, 0);
        chk("post_rst_xmatch", xm_err, 0);
        chk("post_rst_ymatch", ym_err, 0);
        chk("post_rst_drain", drain_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/patch_scanner.md
PATCH_SCANNER -- requirements
Module: patch_scanner

Interface
REQ-001 Parameter IMG_DIM, default 28, image width and height in pixels (square, booleanized).
REQ-002 Parameter MAX_PATCH, default 7, widest patch supported; sets the `pixels` width.
REQ-003 Reset and clock: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  reset
REQ-004 Image write and configuration ports:
- wr_en  in  1  write one image row
- wr_row  in  5  row index 0..IMG_DIM-1
- wr_data  in  IMG_DIM  row bits, bit x = column x
- patch_size  in  3  3, 5 or 7; sampled on start
- x_min, x_max, y_min, y_max  in  5 each  window-origin match bounds, inclusive; sampled on start
REQ-005 Control ports:
- start  in  1  one-cycle pulse, begins a scan
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at scan end
- err_patch  out  1  one-cycle pulse when start is rejected
REQ-006 Streaming ports to the convolution stage:
- pixels  out  MAX_PATCH  current column slice, bit i = row y0+i
- pe_enable  out  1  column valid, shift strobe
- conv_enable  out  1  scan active
- Xmatch  out  1  window-origin x match
- Ymatch  out  1  window-origin y match

Function
REQ-007 Internal image buffer: IMG_DIM rows x IMG_DIM bits.
- Write on wr_en in IDLE only; writes while busy are ignored.
- wr_row >= IMG_DIM is ignored.
REQ-008 FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE->SCAN on start with patch_size in {3,5,7}.
- SCAN->DRAIN after the last column of the last band.
- DRAIN->DONE after MAX_PATCH cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-009 Rejected start: start in IDLE with any other patch_size keeps IDLE and pulses err_patch in the next cycle. start outside IDLE is ignored with no error.
REQ-010 Latching on start: patch_size P and the four bounds are registered on the accepted start and held for the whole scan.
REQ-011 SCAN order: band y0 = 0..IMG_DIM-P, outer loop; column x = 0..IMG_DIM-1, inner loop; one column per clock, no stalls.
- Total SCAN cycles = (IMG_DIM-P+1)*IMG_DIM: 728 for P=3, 672 for P=5, 616 for P=7.
REQ-012 pixels content: bit i = img[y0+i][x] for i < P; bits i >= P = 0.
REQ-013 pe_enable and conv_enable: both high on every SCAN cycle and low in all other states.
REQ-014 Xmatch: asserted on the column equal to the window's left edge x0 = x, so the consumer's internal (P-1)-cycle delay aligns it with the window's last column.
- Xmatch = (x <= IMG_DIM-P) & (x_min <= x <= x_max).
- Columns x > IMG_DIM-P give Xmatch = 0, so windows straddling two bands are never matched.
REQ-015 Ymatch = (y_min <= y0 <= y_max) on every SCAN cycle of band y0.
REQ-016 Band changes are back-to-back: column 0 of band y0+1 directly follows column IMG_DIM-1 of band y0, with no gap cycle.
REQ-017 Latency: accepted start at cycle t gives the first pe_enable at t+1.
- busy is high t+1 through the final DRAIN cycle.
- done is high exactly one cycle, in DONE.
REQ-018 DRAIN: pixels = 0, pe_enable = 0, Xmatch = Ymatch = 0; this flushes the consumer's match delay line.
REQ-019 All outputs are registered. Counters: x and y0 are 5 bits; x wraps IMG_DIM-1 -> 0 while y0 increments.
REQ-020 Simultaneous wr_en and start in IDLE: the write completes, and the scan sees the new row.

Reset
REQ-021 rst asynchronously forces IDLE, clears counters and latched config, and drives all outputs to 0. The image buffer is not cleared.
REQ-022 rst mid-scan aborts immediately and emits no done pulse. The first cycle after release is IDLE.

Structure
REQ-023 The shared package holds:
- IMG_DIM and MAX_PATCH
- patch-size constants PATCH_3/5/7
- the FSM state enumeration
REQ-024 One sub-module, image_buffer: the row array with a write port and an asynchronous row-read port indexed by y0+i. The scanner FSM and counters stay in patch_scanner.

Verification
REQ-025 Checkerboard image, start with P=3 -> exactly 728 pe_enable cycles, done at t+1+728+7.
- Every pixels value matches the model; bits 6:3 are always 0.
REQ-026 P=7 with bounds x_min=0, x_max=21, y_min=0, y_max=21 -> Xmatch count per band = 22, Ymatch high all 616 cycles.
REQ-027 P=5 with bounds x_min=x_max=4, y_min=y_max=10 -> Xmatch and Ymatch are jointly high on exactly one cycle: y0=10, x=4.
REQ-028 start with patch_size=4 -> err_patch pulse one cycle later, busy stays 0, no pe_enable.
REQ-029 wr_en to row 3 during a P=3 scan -> buffer unchanged; the following scan sees the old row 3.
REQ-030 rst asserted at SCAN cycle 100 -> all outputs 0 asynchronously, no done.
- A subsequent start runs a complete, correct scan.
